ntt_stage_scheduler: RTL and testbench
======================================

NTT_STAGE_SCHEDULER -- requirements
Module: ntt_stage_scheduler

Interface
REQ-001 Parameter RING_SIZE, default 256, meaning NTT length; power of two, >= 4; LOG = log2(RING_SIZE), AW = LOG.
REQ-002 Parameter BFLY_LATENCY, default 11, meaning butterfly read-to-write pipeline depth in cycles; >= 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one full NTT; sampled only in IDLE.
REQ-006 busy  output  1  high in ISSUE and DRAIN.
REQ-007 done  output  1  single-cycle completion pulse.
REQ-008 stage  output  ceil(log2(LOG))+1  current stage index s, 0..LOG-1.
REQ-009 rd_valid  output  1  butterfly operand read issued this cycle.
REQ-010 rd_addr_a, rd_addr_b  output  AW each  operand read addresses.
REQ-011 tw_idx  output  AW-1  twiddle ROM index for the issued butterfly.
REQ-012 wr_en  output  1  butterfly result write strobe.
REQ-013 wr_addr_a, wr_addr_b  output  AW each  result write addresses.

Function
REQ-014 States: IDLE, ISSUE, DRAIN, DONE; binary-encoded, one-hot not required.
REQ-015 IDLE: start=1 at a rising edge -> ISSUE; stage=0, butterfly counter j=0.
REQ-016 ISSUE: rd_valid=1 every cycle; one butterfly per cycle, j = 0..RING_SIZE/2-1.
REQ-017 Address rule for stage s, half = 2^s: grp = j>>s, pos = j mod half; rd_addr_a = grp*2*half + pos; rd_addr_b = rd_addr_a + half; tw_idx = pos << (LOG-1-s).
REQ-018 All address arithmetic is unsigned AW-bit; no overflow occurs for legal j, s.
REQ-019 ISSUE with j = RING_SIZE/2-1 -> DRAIN next cycle, j cleared to 0.
REQ-020 DRAIN: rd_valid=0 for exactly BFLY_LATENCY cycles; drain counter counts 0..BFLY_LATENCY-1.
REQ-021 DRAIN end, stage < LOG-1 -> stage increments, ISSUE next cycle.
REQ-022 DRAIN end, stage = LOG-1 -> DONE; DONE lasts one cycle with done=1, then IDLE; stage returns to 0.
REQ-023 Write path: wr_en, wr_addr_a, wr_addr_b equal rd_valid, rd_addr_a, rd_addr_b delayed exactly BFLY_LATENCY cycles via shift register; wr_addr_* held 0 whenever the delayed rd_valid is 0.
REQ-024 The last write of each stage occurs in the final DRAIN cycle; the next stage's first read follows in the next cycle, with no overlap.
REQ-025 start is ignored in ISSUE, DRAIN and DONE; no queuing.
REQ-026 Latency: with start sampled at edge 0, first rd_valid occurs in cycle 1 and done occurs in cycle LOG*(RING_SIZE/2 + BFLY_LATENCY) + 1.
REQ-027 rd_addr_*, tw_idx = 0 whenever rd_valid = 0.
REQ-028 busy=0, done=0 in IDLE; busy=0 in DONE.

Reset
REQ-029 reset low asynchronously forces IDLE; j, stage and drain counter = 0; delay line cleared; all outputs 0.
REQ-030 reset asserted mid-operation aborts the NTT: no further wr_en, no done pulse; after release the block waits in IDLE for start.
REQ-031 Release of reset takes effect at the first rising clk edge; start sampled in that cycle is honoured.

Verification (RING_SIZE=8, BFLY_LATENCY=2 unless stated)
REQ-032 start pulse -> rd pairs stage0 (0,1)(2,3)(4,5)(6,7), tw all 0; stage1 (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
REQ-033 Same run -> each wr_en/wr_addr pair appears exactly 2 cycles after its read; 2 idle read cycles between stages; done in cycle 19, busy high in cycles 1-18.
REQ-034 start held high throughout -> exactly one NTT per IDLE visit; second run's first rd_valid in cycle 21.
REQ-035 reset low in cycle 9 (stage1) -> outputs 0 immediately; no done; new start after release gives a full 18-cycle run from stage 0.
REQ-036 RING_SIZE=256, BFLY_LATENCY=11 -> done in cycle 8*(128+11)+1 = 1113; 1024 rd_valid and 1024 wr_en cycles total.

Source files
------------

// File: rtl/ntt_stage_scheduler.sv
// Address and control sequencer for an in-place radix-2 NTT: issues one butterfly
// read per cycle, drains the butterfly pipeline between stages, and replays writes.
module ntt_stage_scheduler #(
    parameter  int RING_SIZE    = 256,
    parameter  int BFLY_LATENCY = 11,
    localparam int LOG          = $clog2(RING_SIZE),
    localparam int AW           = LOG,
    localparam int SW           = $clog2(LOG) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] stage,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic [AW-2:0] tw_idx,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b
);

    localparam int BW = AW - 1;
    localparam int DW = (BFLY_LATENCY > 1) ? $clog2(BFLY_LATENCY) : 1;

    localparam logic [BW-1:0] J_LAST = BW'(RING_SIZE / 2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BFLY_LATENCY - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [BW-1:0] r_j;
    logic [SW-1:0] r_stage;
    logic [DW-1:0] r_drain;

    logic          w_last_bfly;
    logic          w_drain_end;
    logic          w_last_stage;

    logic [AW-1:0] w_j;
    logic [AW-1:0] w_half;
    logic [AW-1:0] w_pos;
    logic [AW-1:0] w_grp;
    logic [AW-1:0] w_addr_a;
    logic [AW-1:0] w_addr_b;
    logic [SW-1:0] w_tw_shift;
    logic [BW-1:0] w_tw;

    logic          r_dly_valid [BFLY_LATENCY];
    logic [AW-1:0] r_dly_a     [BFLY_LATENCY];
    logic [AW-1:0] r_dly_b     [BFLY_LATENCY];

    assign w_last_bfly  = (r_j == J_LAST);
    assign w_drain_end  = (r_drain == D_LAST);
    assign w_last_stage = (r_stage == S_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_bfly) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_end) begin
                    w_next_state = w_last_stage ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_j     <= '0;
            r_stage <= '0;
            r_drain <= '0;
        end else begin
            unique case (r_state)
                S_ISSUE: begin
                    r_j <= w_last_bfly ? '0 : r_j + BW'(1);
                end
                S_DRAIN: begin
                    r_drain <= w_drain_end ? '0 : r_drain + DW'(1);
                    if (w_drain_end && !w_last_stage) begin
                        r_stage <= r_stage + SW'(1);
                    end
                end
                S_DONE: begin
                    r_stage <= '0;
                end
                default: begin
                    r_j     <= '0;
                    r_stage <= '0;
                    r_drain <= '0;
                end
            endcase
        end
    end

    // Operand a is j with a zero bit inserted at position s; b sets that bit.
    always_comb begin
        w_j        = {1'b0, r_j};
        w_half     = AW'(1) << r_stage;
        w_pos      = w_j & (w_half - AW'(1));
        w_grp      = w_j >> r_stage;
        w_addr_a   = ((w_grp << r_stage) << 1) | w_pos;
        w_addr_b   = w_addr_a + w_half;
        w_tw_shift = S_LAST - r_stage;
        w_tw       = w_pos[BW-1:0] << w_tw_shift;
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        stage     = r_stage;
        rd_valid  = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_idx    = '0;
        unique case (r_state)
            S_ISSUE: begin
                busy      = 1'b1;
                rd_valid  = 1'b1;
                rd_addr_a = w_addr_a;
                rd_addr_b = w_addr_b;
                tw_idx    = w_tw;
            end
            S_DRAIN: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
        wr_en     = r_dly_valid[BFLY_LATENCY-1];
        wr_addr_a = r_dly_a[BFLY_LATENCY-1];
        wr_addr_b = r_dly_b[BFLY_LATENCY-1];
    end

    // NOTE: the delay line is reset, unlike a data RAM, because an aborted run
    // must not leak stale write strobes after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BFLY_LATENCY; i++) begin
                r_dly_valid[i] <= 1'b0;
                r_dly_a[i]     <= '0;
                r_dly_b[i]     <= '0;
            end
        end else begin
            r_dly_valid[0] <= rd_valid;
            r_dly_a[0]     <= rd_addr_a;
            r_dly_b[0]     <= rd_addr_b;
            for (int i = 1; i < BFLY_LATENCY; i++) begin
                r_dly_valid[i] <= r_dly_valid[i-1];
                r_dly_a[i]     <= r_dly_a[i-1];
                r_dly_b[i]     <= r_dly_b[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Self-checking bench: a small (8/2) and a full-size (256/11) scheduler compared
// cycle by cycle against a timeline model built from the NTT schedule arithmetic.
module tb_ntt_stage_scheduler;

    localparam int N_S = 8;
    localparam int L_S = 2;
    localparam int N_L = 256;
    localparam int L_L = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_s, start_s, reset_l, start_l;

    logic       s_busy, s_done, s_rd_valid, s_wr_en;
    logic [2:0] s_stage, s_ra, s_rb, s_wa, s_wb;
    logic [1:0] s_tw;

    logic       l_busy, l_done, l_rd_valid, l_wr_en;
    logic [3:0] l_stage;
    logic [7:0] l_ra, l_rb, l_wa, l_wb;
    logic [6:0] l_tw;

    ntt_stage_scheduler #(.RING_SIZE(N_S), .BFLY_LATENCY(L_S)) dut_s (
        .clk(clk), .reset(reset_s), .start(start_s),
        .busy(s_busy), .done(s_done), .stage(s_stage),
        .rd_valid(s_rd_valid), .rd_addr_a(s_ra), .rd_addr_b(s_rb), .tw_idx(s_tw),
        .wr_en(s_wr_en), .wr_addr_a(s_wa), .wr_addr_b(s_wb)
    );

    ntt_stage_scheduler #(.RING_SIZE(N_L), .BFLY_LATENCY(L_L)) dut_l (
        .clk(clk), .reset(reset_l), .start(start_l),
        .busy(l_busy), .done(l_done), .stage(l_stage),
        .rd_valid(l_rd_valid), .rd_addr_a(l_ra), .rd_addr_b(l_rb), .tw_idx(l_tw),
        .wr_en(l_wr_en), .wr_addr_a(l_wa), .wr_addr_b(l_wb)
    );

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int mdl_s = 0;
    int mdl_l = 0;

    int s_busy_cnt = 0;
    logic s_prev_busy = 1'b0;
    int s_busy_rise[$];
    int s_done_q[$];
    int l_rd_cnt = 0;
    int l_wr_cnt = 0;
    int l_done_at = -1;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pack(input int busy, input int done, input int stage,
                                         input int rdv, input int ra, input int rb, input int tw,
                                         input int wen, input int wa, input int wb);
        return {8'(busy), 8'(done), 8'(stage), 8'(rdv), 8'(ra), 8'(rb), 8'(tw),
                8'(wen), 8'(wa), 8'(wb)};
    endfunction

    // Butterfly j of stage s pairs indices that differ only in bit s.
    function automatic void bfly(input int n, input int s, input int j,
                                 output int ra, output int rb, output int tw);
        int half, grp, pos;
        half = 1 << s;
        grp  = j / half;
        pos  = j % half;
        ra   = grp * 2 * half + pos;
        rb   = ra + half;
        tw   = pos * (1 << ($clog2(n) - 1 - s));
    endfunction

    // Expected outputs t cycles after start was sampled (t = 0 means idle).
    function automatic logic [79:0] model(input int n, input int l, input int t);
        int lg, p, bf, busy, done, stg, rdv, ra, rb, tw, wen, wa, wb, tr, dummy;
        lg = $clog2(n);
        bf = n / 2;
        p  = bf + l;
        busy = 0; done = 0; stg = 0; rdv = 0; ra = 0; rb = 0; tw = 0;
        wen = 0; wa = 0; wb = 0;
        if (t >= 1 && t <= lg * p) begin
            busy = 1;
            stg  = (t - 1) / p;
            if ((t - 1) % p < bf) begin
                rdv = 1;
                bfly(n, stg, (t - 1) % p, ra, rb, tw);
            end
            tr = t - l;
            if (tr >= 1 && (tr - 1) % p < bf) begin
                wen = 1;
                bfly(n, (tr - 1) / p, (tr - 1) % p, wa, wb, dummy);
            end
        end else if (t == lg * p + 1) begin
            done = 1;
            stg  = lg - 1;
        end
        return pack(busy, done, stg, rdv, ra, rb, tw, wen, wa, wb);
    endfunction

    function automatic int advance(input int n, input int l, input int m,
                                   input logic rst, input logic st);
        int last;
        last = $clog2(n) * (n / 2 + l) + 1;
        if (!rst)          return 0;
        else if (m == 0)   return st ? 1 : 0;
        else if (m == last) return 0;
        else               return m + 1;
    endfunction

    // One clock cycle: apply inputs at the falling edge, compare, then cross the rising edge.
    task automatic cycle(input logic rs, input logic ss, input logic rl, input logic sl);
        reset_s = rs; start_s = ss; reset_l = rl; start_l = sl;
        if (!rs) mdl_s = 0;
        if (!rl) mdl_l = 0;
        #1;
        check($sformatf("s_cyc%0d", cyc),
              pack(s_busy, s_done, s_stage, s_rd_valid, s_ra, s_rb, s_tw, s_wr_en, s_wa, s_wb),
              model(N_S, L_S, mdl_s));
        check($sformatf("l_cyc%0d", cyc),
              pack(l_busy, l_done, l_stage, l_rd_valid, l_ra, l_rb, l_tw, l_wr_en, l_wa, l_wb),
              model(N_L, L_L, mdl_l));
        if (s_busy) s_busy_cnt++;
        if (s_busy && !s_prev_busy) s_busy_rise.push_back(cyc);
        s_prev_busy = s_busy;
        if (s_done) s_done_q.push_back(cyc);
        if (l_rd_valid) l_rd_cnt++;
        if (l_wr_en) l_wr_cnt++;
        if (l_done) l_done_at = cyc;
        @(posedge clk);
        mdl_s = advance(N_S, L_S, mdl_s, rs, ss);
        mdl_l = advance(N_L, L_L, mdl_l, rl, sl);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int c0;
        int n_done;

        reset_s = 1'b0; start_s = 1'b0; reset_l = 1'b0; start_l = 1'b0;
        #1;
        check("reset_small", pack(s_busy, s_done, s_stage, s_rd_valid, s_ra, s_rb, s_tw,
                                  s_wr_en, s_wa, s_wb), '0);
        check("reset_large", pack(l_busy, l_done, l_stage, l_rd_valid, l_ra, l_rb, l_tw,
                                  l_wr_en, l_wa, l_wb), '0);
        @(negedge clk);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Single start pulse: done at cycle 19, busy in cycles 1..18.
        s_busy_cnt = 0; s_done_q.delete();
        c0 = cyc;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (22) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("pulse_done_cycle", (s_done_q.size() == 1) ? s_done_q[0] - c0 : -1, 19);
        check("pulse_busy_cycles", s_busy_cnt, 18);

        // Start held high: one run per IDLE visit, second run starts at cycle 21.
        s_busy_rise.delete(); s_done_q.delete();
        c0 = cyc;
        repeat (40) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("held_runs", s_busy_rise.size(), 2);
        check("held_first_rd", (s_busy_rise.size() > 0) ? s_busy_rise[0] - c0 : -1, 1);
        check("held_second_rd", (s_busy_rise.size() > 1) ? s_busy_rise[1] - c0 : -1, 21);
        check("held_second_done", (s_done_q.size() > 1) ? s_done_q[1] - c0 : -1, 39);

        // Reset in cycle 9 aborts the run; a later start gives a clean full run.
        s_done_q.delete();
        c0 = cyc;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (8) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_outputs", pack(s_busy, s_done, s_stage, s_rd_valid, s_ra, s_rb, s_tw,
                                    s_wr_en, s_wa, s_wb), '0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("abort_no_done", s_done_q.size(), 0);
        s_busy_cnt = 0;
        c0 = cyc;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (20) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("rerun_done_cycle", (s_done_q.size() == 1) ? s_done_q[0] - c0 : -1, 19);
        check("rerun_busy_cycles", s_busy_cnt, 18);

        // Full-size instance: latency and total read/write counts.
        l_rd_cnt = 0; l_wr_cnt = 0; l_done_at = -1;
        c0 = cyc;
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        n_done = 0;
        while (l_done_at < 0 && n_done < 2000) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0);
            n_done++;
        end
        check("large_done_cycle", (l_done_at >= 0) ? l_done_at - c0 : -1, 1113);
        check("large_rd_count", l_rd_cnt, 1024);
        check("large_wr_count", l_wr_cnt, 1024);
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        // Random start and occasional reset on the small instance.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) == 0), 1'b1, 1'b0);
        end
        repeat (25) cycle(1'b1, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
